step_input_conditioner: RTL and testbench

Conditions the raw board pushbutton and slide switch into clean, clock-synchronous stimulus for the sequence state machine. Both raw inputs are synchronised and debounced. The button generates single-cycle `step` pulses, with optional auto-repeat while held. The switch value is latched as `in_bit` on every step. Sits directly upstream of the 6-state Mealy sequence machine, whose `in` is driven by `in_bit` and whose clock enable is driven by `step`.

---
 rtl/step_input_conditioner.sv | 161 ++++++++++++++++
 tb/tb_step_input_conditioner.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/step_input_conditioner.sv
// step_input_conditioner
//   Turns the raw board pushbutton and slide switch into clean, clock-synchronous
//   stimulus for the downstream sequence machine. Both inputs are synchronised and
//   debounced. A press gives a single-cycle step pulse, and holding the button can
//   auto-repeat. The debounced switch value is latched on every step.
//
// Ports
//   clk         system clock, all logic on posedge
//   reset       asynchronous, active-low reset
//   btn_raw     raw pushbutton (active-high, asynchronous, bouncy)
//   sw_raw      raw slide switch (asynchronous, bouncy)
//   step        registered one-cycle advance pulse
//   in_bit      debounced switch value captured on each step, held between steps
//   btn_level   debounced button level (LED drive)
//   step_count  number of steps issued, modulo 256
//
// Step FSM
//   state  | meaning
//   IDLE   | button released; the next debounced press issues a step
//   HELD   | button held after the press step; waiting REPEAT_DELAY for the first repeat
//   REPEAT | button still held; a step is issued every REPEAT_PERIOD cycles
module step_input_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = 32,
  parameter int REPEAT_PERIOD   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_raw,
  input  logic       sw_raw,
  output logic       step,
  output logic       in_bit,
  output logic       btn_level,
  output logic [7:0] step_count
);

  localparam int DBW     = $clog2(DEBOUNCE_CYCLES);
  localparam int RC_SPAN = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RCW     = $clog2(RC_SPAN);

  localparam logic [DBW-1:0] DB_LAST     = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RCW-1:0] DELAY_LAST  = RCW'(REPEAT_DELAY - 1);
  localparam logic [RCW-1:0] PERIOD_LAST = RCW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  // Channel 0 is the button, channel 1 the switch.
  logic [1:0] raw_in;
  logic [1:0] db_q;
  logic       db_btn;
  logic       db_sw;

  assign raw_in = {sw_raw, btn_raw};

  for (genvar g = 0; g < 2; g++) begin : g_db
    logic [SYNC_STAGES-1:0] sync_q;
    logic [DBW-1:0]         cnt_q;
    logic                   stable_q;

    // The counter tracks consecutive cycles the synchronised input disagrees
    // with the stable value; any agreeing cycle restarts it, so short glitches
    // never reach the terminal count.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        sync_q   <= '0;
        cnt_q    <= '0;
        stable_q <= 1'b0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in[g]};
        if (sync_q[SYNC_STAGES-1] == stable_q) begin
          cnt_q <= '0;
        end else if (cnt_q == DB_LAST) begin
          stable_q <= sync_q[SYNC_STAGES-1];
          cnt_q    <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end

    assign db_q[g] = stable_q;
  end

  assign db_btn    = db_q[0];
  assign db_sw     = db_q[1];
  assign btn_level = db_btn;

  state_t         state_q, state_d;
  logic [RCW-1:0] rc_q, rc_d;
  logic           step_d;

  // Release is tested before the repeat terminal count, so a release landing on
  // the same cycle as a due repeat suppresses that step.
  always_comb begin
    state_d = state_q;
    rc_d    = rc_q;
    step_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (db_btn) begin
          step_d  = 1'b1;
          rc_d    = '0;
          state_d = HELD;
        end
      end
      HELD: begin
        if (!db_btn) begin
          state_d = IDLE;
        end else if ((REPEAT_EN != 0) && (rc_q == DELAY_LAST)) begin
          step_d  = 1'b1;
          rc_d    = '0;
          state_d = REPEAT;
        end else if (rc_q != DELAY_LAST) begin
          // With repeat disabled the count parks at the delay terminal value.
          rc_d = rc_q + 1'b1;
        end
      end
      REPEAT: begin
        if (!db_btn) begin
          state_d = IDLE;
        end else if (rc_q == PERIOD_LAST) begin
          step_d = 1'b1;
          rc_d   = '0;
        end else begin
          rc_d = rc_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        rc_d    = '0;
      end
    endcase
  end

  // in_bit samples db_sw on the same edge that registers the step, so a switch
  // change landing on that edge is not seen until the next step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      rc_q       <= '0;
      step       <= 1'b0;
      in_bit     <= 1'b0;
      step_count <= 8'd0;
    end else begin
      state_q <= state_d;
      rc_q    <= rc_d;
      step    <= step_d;
      if (step_d) begin
        in_bit     <= db_sw;
        step_count <= step_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_step_input_conditioner.sv
module tb_step_input_conditioner;

  localparam int S  = 2;
  localparam int D  = 16;
  localparam int RD = 32;
  localparam int RP = 8;

  logic       clk     = 1'b0;
  logic       reset   = 1'b0;
  logic       btn_raw = 1'b0;
  logic       sw_raw  = 1'b0;
  logic       step, in_bit, btn_level;
  logic [7:0] step_count;
  logic       step_nr, in_bit_nr, btn_level_nr;
  logic [7:0] step_count_nr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  step_input_conditioner dut (
    .clk(clk), .reset(reset), .btn_raw(btn_raw), .sw_raw(sw_raw),
    .step(step), .in_bit(in_bit), .btn_level(btn_level), .step_count(step_count)
  );

  step_input_conditioner #(.REPEAT_EN(0)) dut_nr (
    .clk(clk), .reset(reset), .btn_raw(btn_raw), .sw_raw(sw_raw),
    .step(step_nr), .in_bit(in_bit_nr), .btn_level(btn_level_nr), .step_count(step_count_nr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: raw samples are kept per edge; the debounced value flips
  // when the synchronised view (raw delayed by S edges) has disagreed with it
  // for the last D edges with no flip in between. Steps are scheduled from the
  // edge the debounced button rose: +1, then +1+RD, then every RP.
  bit         ring [0:1][0:63];
  bit         st [0:1];
  int         lf [0:1];
  int         mn, rise, h;
  bit         sn, sn_nr, all_mis;
  logic       m_step = 1'b0, m_in = 1'b0, m_step_nr = 1'b0, m_in_nr = 1'b0;
  logic [7:0] m_cnt = 8'd0, m_cnt_nr = 8'd0;

  function automatic bit raw_at(input int ch, input int j);
    if (j < 1) return 1'b0;
    return ring[ch][j % 64];
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      mn = 0; rise = 0;
      st[0] = 1'b0; st[1] = 1'b0; lf[0] = 0; lf[1] = 0;
      m_step = 1'b0; m_in = 1'b0; m_cnt = 8'd0;
      m_step_nr = 1'b0; m_in_nr = 1'b0; m_cnt_nr = 8'd0;
    end else begin
      mn++;
      ring[0][mn % 64] = btn_raw;
      ring[1][mn % 64] = sw_raw;
      h     = mn - rise;
      sn    = st[0] && ((h == 1) || ((h >= 1 + RD) && ((h - 1 - RD) % RP == 0)));
      sn_nr = st[0] && (h == 1);
      m_step    = sn;
      m_step_nr = sn_nr;
      if (sn)    begin m_in    = st[1]; m_cnt++;    end
      if (sn_nr) begin m_in_nr = st[1]; m_cnt_nr++; end
      for (int ch = 0; ch < 2; ch++) begin
        all_mis = (mn - lf[ch] >= D);
        for (int k = mn - D + 1; k <= mn; k++)
          if (raw_at(ch, k - S) == st[ch]) all_mis = 1'b0;
        if (all_mis) begin
          st[ch] = !st[ch];
          lf[ch] = mn;
          if (ch == 0 && st[0]) rise = mn;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("step", step, m_step);
    chk("in_bit", in_bit, m_in);
    chk("btn_level", btn_level, st[0]);
    chk("step_count", step_count, m_cnt);
    chk("nr_step", step_nr, m_step_nr);
    chk("nr_in_bit", in_bit_nr, m_in_nr);
    chk("nr_btn_level", btn_level_nr, st[0]);
    chk("nr_step_count", step_count_nr, m_cnt_nr);
  end

  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic do_reset();
    #2 reset = 1'b0;
    tick(2);
    #2 reset = 1'b1;
  endtask

  // Waits for a step pulse; returns the number of negedges waited (limit on timeout).
  task automatic wait_step(input int limit, output int e);
    e = 0;
    do begin
      @(negedge clk);
      e++;
    end while (!step && e < limit);
  endtask

  task automatic wait_level(input int limit);
    int e;
    e = 0;
    while (!btn_level && e < limit) begin
      @(negedge clk);
      e++;
    end
    chk("level_rise", btn_level, 1);
  endtask

  initial begin
    int   e, cnt, cnt_nr, lvl, br, sr;
    logic [7:0] c0;
    logic lvl39, lvl40;
    int   pos[$];

    // Reset with both inputs high, then first step after the full latency.
    btn_raw = 1'b1; sw_raw = 1'b1;
    tick(3);
    chk("rst_step", step, 0);
    chk("rst_in_bit", in_bit, 0);
    chk("rst_btn_level", btn_level, 0);
    chk("rst_step_count", step_count, 0);
    #2 reset = 1'b1;
    wait_step(100, e);
    chk("first_step_edge", e, 19);
    chk("first_in_bit", in_bit, 1);
    chk("first_count", step_count, 1);
    btn_raw = 1'b0;
    tick(40);

    // Bounce rejection: high pulses of 1..15 cycles.
    cnt = 0; lvl = 0;
    for (int p = 1; p <= 15; p++) begin
      btn_raw = 1'b1;
      repeat (p) begin @(negedge clk); cnt += step; lvl |= btn_level; end
      btn_raw = 1'b0;
      repeat ($urandom_range(1, 6)) begin @(negedge clk); cnt += step; lvl |= btn_level; end
    end
    repeat (30) begin @(negedge clk); cnt += step; lvl |= btn_level; end
    chk("bounce_steps", cnt, 0);
    chk("bounce_level", lvl, 0);

    // Single press on the no-repeat instance, then release latency.
    c0 = step_count_nr; cnt = 0;
    btn_raw = 1'b1;
    repeat (200) begin @(negedge clk); cnt += step_nr; end
    chk("norep_steps", cnt, 1);
    chk("norep_count", 8'(step_count_nr - c0), 1);
    btn_raw = 1'b0;
    tick(17);
    chk("release_level17", btn_level, 1);
    tick(1);
    chk("release_level18", btn_level, 0);
    tick(10);

    // Auto-repeat spacing over 100 cycles after the level rises.
    btn_raw = 1'b1;
    wait_level(100);
    pos.delete(); cnt_nr = 0;
    for (int rel = 1; rel <= 100; rel++) begin
      @(negedge clk);
      if (step) pos.push_back(rel);
      cnt_nr += step_nr;
    end
    chk("rep_count", pos.size(), 10);
    for (int i = 0; i < 10; i++)
      if (i < pos.size()) chk("rep_pos", pos[i], (i == 0) ? 1 : 1 + RD + RP * (i - 1));
    chk("rep_nr_count", cnt_nr, 1);
    btn_raw = 1'b0;
    tick(40);

    // Switch settles on the very edge the step is issued: old value captured.
    sw_raw = 1'b0;
    tick(30);
    btn_raw = 1'b1;
    tick(1);
    sw_raw = 1'b1;
    wait_step(60, e);
    chk("order_found", step, 1);
    chk("order_in_bit", in_bit, 0);
    btn_raw = 1'b0;
    tick(40);

    // Alternate the switch between presses.
    for (int i = 0; i < 6; i++) begin
      sw_raw = (i % 2) == 1;
      tick(30);
      btn_raw = 1'b1;
      wait_step(60, e);
      chk("cap_found", step, 1);
      chk("cap_in_bit", in_bit, i % 2);
      btn_raw = 1'b0;
      tick(40);
    end

    // 257 steps from reset wrap the counter to 1.
    btn_raw = 1'b1;
    do_reset();
    cnt = 0; e = 0;
    while (cnt < 257 && e < 5000) begin
      @(negedge clk);
      e++;
      cnt += step;
    end
    chk("wrap_steps", cnt, 257);
    chk("wrap_count", step_count, 1);
    btn_raw = 1'b0;
    tick(40);

    // Release lands on the edge the second repeat is due: no step.
    btn_raw = 1'b1;
    wait_level(100);
    pos.delete(); lvl39 = 1'b0; lvl40 = 1'b1;
    for (int rel = 1; rel <= 60; rel++) begin
      @(negedge clk);
      if (step) pos.push_back(rel);
      if (rel == 22) btn_raw = 1'b0;
      if (rel == 39) lvl39 = btn_level;
      if (rel == 40) lvl40 = btn_level;
    end
    chk("race_steps", pos.size(), 2);
    if (pos.size() > 1) chk("race_pos", pos[1], 1 + RD);
    chk("race_level39", lvl39, 1);
    chk("race_level40", lvl40, 0);
    tick(20);
    btn_raw = 1'b1;
    wait_step(100, e);
    chk("repress_edge", e, 19);
    btn_raw = 1'b0;
    tick(40);

    // Random bouncy inputs with occasional mid-operation resets.
    br = 1; sr = 1;
    for (int c = 0; c < 3000; c++) begin
      br--;
      if (br <= 0) begin btn_raw = ~btn_raw; br = $urandom_range(1, 60); end
      sr--;
      if (sr <= 0) begin sw_raw = ~sw_raw; sr = $urandom_range(1, 25); end
      if ($urandom_range(0, 599) == 0) do_reset();
      tick(1);
    end

    btn_raw = 1'b0;
    tick(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
